// File: rtl/softmax_norm_feeder_pkg.sv
// Shared types and helpers for the softmax normalisation feeder.
package softmax_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  localparam int DEN_MIN = 1;

  function automatic int sum_width(input int bitwidth, input int row_len);
    return bitwidth + $clog2(row_len);
  endfunction

endpackage

// File: rtl/softmax_norm_feeder_if.sv
// Input beat stream and divider operand stream of the softmax feeder.
interface softmax_norm_feeder_if #(
  parameter int BITWIDTH = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] num_out;
  logic [BITWIDTH-1:0] den_out;
  logic                out_last;
  logic                row_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, num_out, den_out, out_last, row_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, num_out, den_out, out_last, row_err
  );
endinterface

// File: rtl/softmax_norm_feeder_row_buffer.sv
// Row storage: synchronous write, combinational read, data is not reset.
module softmax_row_buffer #(
  parameter int BITWIDTH = 16,
  parameter int ROW_LEN  = 64,
  localparam int AW      = $clog2(ROW_LEN)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [BITWIDTH-1:0] rdata
);

  logic [BITWIDTH-1:0] mem_r [ROW_LEN];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/softmax_norm_feeder.sv
// Softmax row feeder: buffers a row, sums it, then replays num/den pairs.
// Optional feature: SOFTMAX_FEEDER_ZERO_GUARD_EN forces the denominator to be at least 1.
module softmax_norm_feeder
  import softmax_pkg::*;
#(
  parameter int BITWIDTH  = 16,
  parameter int ROW_LEN   = 64,
  parameter int FRAC_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  softmax_norm_feeder_if.slave bus
);

  localparam int AW    = $clog2(ROW_LEN);
  localparam int CW    = AW + 1;
  localparam int SUM_W = sum_width(BITWIDTH, ROW_LEN);
  localparam logic [SUM_W-1:0] DEN_MAX = {{(SUM_W-BITWIDTH){1'b0}}, {BITWIDTH{1'b1}}};

  state_e              state_r, state_next_s;
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r, rd_next_s, raddr_s;
  logic [CW-1:0]       count_r;
  logic [SUM_W-1:0]    sum_r, sum_next_s, den_raw_s;
  logic [BITWIDTH-1:0] den_sat_s, den_s, rdata_s, first_s;
  logic [BITWIDTH-1:0] num_r, den_r;
  logic                in_ready_r, out_valid_r, out_last_r, row_err_r;
  logic                accept_s, take_s, full_s, row_end_s, trunc_s, done_s;

  assign accept_s   = bus.in_valid && (state_r == ACCUM);
  assign take_s     = out_valid_r && bus.out_ready;
  assign full_s     = (wr_ptr_r == AW'(ROW_LEN - 1));
  assign row_end_s  = accept_s && (bus.in_last || full_s);
  assign trunc_s    = accept_s && full_s && !bus.in_last;
  assign done_s     = take_s && out_last_r;
  assign rd_next_s  = rd_ptr_r + AW'(1'b1);
  assign sum_next_s = sum_r + SUM_W'(bus.in_data);

  // During ACCUM the read port looks at entry 0 so the first pair is ready on entry to EMIT
  assign raddr_s = (state_r == ACCUM) ? '0 : rd_next_s;
  assign first_s = (wr_ptr_r == '0) ? bus.in_data : rdata_s;

  softmax_row_buffer #(
    .BITWIDTH (BITWIDTH),
    .ROW_LEN  (ROW_LEN)
  ) u_row_buffer (
    .clk   (clk),
    .we    (accept_s),
    .waddr (wr_ptr_r),
    .wdata (bus.in_data),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Denominator: scale the final row sum, saturate, optionally guard against zero
  always_comb begin
    den_raw_s = sum_next_s >> FRAC_BITS;
    if (den_raw_s > DEN_MAX) begin
      den_sat_s = '1;
    end else begin
      den_sat_s = den_raw_s[BITWIDTH-1:0];
    end
`ifdef SOFTMAX_FEEDER_ZERO_GUARD_EN
    if (den_sat_s == '0) begin
      den_s = BITWIDTH'(DEN_MIN);
    end else begin
      den_s = den_sat_s;
    end
`else
    den_s = den_sat_s;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ACCUM: begin
        if (row_end_s) begin
          state_next_s = EMIT;
        end else begin
          state_next_s = ACCUM;
        end
      end
      EMIT: begin
        if (done_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = EMIT;
        end
      end
      default: state_next_s = ACCUM;
    endcase
  end

  // Pointers, accumulator and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      sum_r       <= '0;
      num_r       <= '0;
      den_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      row_err_r   <= 1'b0;
    end else begin
      row_err_r  <= trunc_s;
      in_ready_r <= (state_next_s == ACCUM);
      if (accept_s) begin
        sum_r    <= sum_next_s;
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (row_end_s) begin
        out_valid_r <= 1'b1;
        den_r       <= den_s;
        num_r       <= first_s;
        out_last_r  <= (wr_ptr_r == '0);
        count_r     <= CW'(wr_ptr_r) + CW'(1'b1);
        rd_ptr_r    <= '0;
      end else if (done_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        sum_r       <= '0;
        wr_ptr_r    <= '0;
        rd_ptr_r    <= '0;
      end else if (take_s) begin
        rd_ptr_r   <= rd_next_s;
        num_r      <= rdata_s;
        out_last_r <= ({1'b0, rd_next_s} == (count_r - CW'(1'b1)));
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.num_out   = num_r;
  assign bus.den_out   = den_r;
  assign bus.out_last  = out_last_r;
  assign bus.row_err   = row_err_r;

endmodule

// File: tb/tb_softmax_norm_feeder.sv
// Self-checking bench: two feeders (FRAC_BITS 8 and 0) fed with identical stimulus.
module tb_softmax_norm_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_q[$];

  always #5 clk = ~clk;

  softmax_norm_feeder_if #(.BITWIDTH(16)) bus8 ();
  softmax_norm_feeder_if #(.BITWIDTH(16)) bus0 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_data   = in_data;
  assign bus8.in_last   = in_last;
  assign bus8.out_ready = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.in_last   = in_last;
  assign bus0.out_ready = out_ready;

  softmax_norm_feeder #(.BITWIDTH(16), .ROW_LEN(4), .FRAC_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));
  softmax_norm_feeder #(.BITWIDTH(16), .ROW_LEN(4), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  // Probability denominator from the row sum: floor(sum / 2^f), clipped, optional zero guard
  function automatic logic [15:0] model_den(input int s, input int f);
    int q;
    q = s / (1 << f);
    if (q > 65535) q = 65535;
`ifdef SOFTMAX_FEEDER_ZERO_GUARD_EN
    if (q == 0) q = 1;
`endif
    return 16'(q);
  endfunction

  task automatic drive_beat(input logic [15:0] d, input logic l);
    int w;
    in_valid = 1'b1; in_data = d; in_last = l; w = 0;
    while (bus8.in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 40) begin
      n_vec++; n_bad++;
      $display("FAIL beat_accept: in_ready=%b after %0d cycles, want 1", bus8.in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_row();
    for (int i = 0; i < exp_q.size(); i++) drive_beat(16'(exp_q[i]), (i == exp_q.size() - 1));
  endtask

  // Consumes the pairs of the row in exp_q, starting in the cycle after the last accept
  task automatic check_emit(input string name, input logic exp_err, input int stall_idx,
                            input bit rnd_stall);
    int n, s;
    logic [15:0] d8, d0, e;
    logic lst;
    n = exp_q.size(); s = 0;
    foreach (exp_q[i]) s += exp_q[i];
    d8 = model_den(s, 8); d0 = model_den(s, 0);
    for (int k = 0; k < n; k++) begin
      e = 16'(exp_q[k]);
      lst = (k == n - 1);
      if (k > 0 && (k == stall_idx || (rnd_stall && $urandom_range(0, 2) == 0))) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          n_vec++;
          if (bus8.out_valid !== 1'b1 || bus8.num_out !== e || bus8.in_ready !== 1'b0 ||
              bus8.out_last !== lst || bus8.den_out !== d8) begin
            n_bad++;
            $display("FAIL %s_stall pair %0d: valid=%b num=%0d den=%0d in_ready=%b last=%b, want 1 %0d %0d 0 %b",
                     name, k, bus8.out_valid, bus8.num_out, bus8.den_out, bus8.in_ready, bus8.out_last, e, d8, lst);
          end
        end
      end
      out_ready = 1'b1;
      n_vec++;
      if (bus8.out_valid !== 1'b1 || bus8.num_out !== e || bus8.out_last !== lst) begin
        n_bad++;
        $display("FAIL %s_pair8 %0d: valid=%b num=%0d last=%b, want 1 %0d %b",
                 name, k, bus8.out_valid, bus8.num_out, bus8.out_last, e, lst);
      end
      n_vec++;
      if (bus0.out_valid !== 1'b1 || bus0.num_out !== e || bus0.out_last !== lst) begin
        n_bad++;
        $display("FAIL %s_pair0 %0d: valid=%b num=%0d last=%b, want 1 %0d %b",
                 name, k, bus0.out_valid, bus0.num_out, bus0.out_last, e, lst);
      end
      n_vec++;
      if (bus8.den_out !== d8 || bus0.den_out !== d0) begin
        n_bad++;
        $display("FAIL %s_den %0d: den8=%0d den0=%0d, want %0d %0d",
                 name, k, bus8.den_out, bus0.den_out, d8, d0);
      end
      n_vec++;
      if (bus8.row_err !== (exp_err && k == 0) || bus0.row_err !== (exp_err && k == 0) ||
          bus8.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_ctrl %0d: row_err=%b/%b in_ready=%b, want %b 0",
                 name, k, bus8.row_err, bus0.row_err, bus8.in_ready, exp_err && k == 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    n_vec++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.row_err !== 1'b0 ||
        bus0.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_end: out_valid=%b/%b in_ready=%b row_err=%b, want 0 0 1 0",
               name, bus8.out_valid, bus0.out_valid, bus8.in_ready, bus8.row_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_last !== 1'b0 ||
        bus8.row_err !== 1'b0 || bus8.num_out !== 16'd0 || bus8.den_out !== 16'd0) begin
      n_bad++;
      $display("FAIL reset8: rdy=%b val=%b last=%b err=%b num=%0d den=%0d, want 1 0 0 0 0 0",
               bus8.in_ready, bus8.out_valid, bus8.out_last, bus8.row_err, bus8.num_out, bus8.den_out);
    end
    n_vec++;
    if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.den_out !== 16'd0) begin
      n_bad++;
      $display("FAIL reset0: rdy=%b val=%b den=%0d, want 1 0 0", bus0.in_ready, bus0.out_valid, bus0.den_out);
    end
  endtask

  task automatic test_basic();
    exp_q = '{256, 512, 256, 0};
    send_row();
    check_emit("basic", 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_q = '{256, 512, 256, 0};
    send_row();
    check_emit("backpressure", 1'b0, 1, 1'b0);
  endtask

  task automatic test_zero_guard();
    exp_q = '{0, 0};
    send_row();
    check_emit("zero_guard", 1'b0, -1, 1'b0);
  endtask

  task automatic test_truncation();
    exp_q = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) drive_beat(16'(i + 1), 1'b0);
    in_valid = 1'b1; in_data = 16'd5; in_last = 1'b1;
    check_emit("truncation", 1'b1, 2, 1'b0);
    exp_q = '{5};
    drive_beat(16'd5, 1'b1);
    check_emit("trunc_next", 1'b0, -1, 1'b0);
  endtask

  task automatic test_saturation();
    exp_q = '{65535, 65535, 65535, 65535};
    send_row();
    check_emit("saturation", 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(1, 4);
      exp_q = {};
      for (int i = 0; i < len; i++)
        exp_q.push_back((r % 3 == 0) ? $urandom_range(0, 300) : $urandom_range(0, 65535));
      send_row();
      check_emit("random", 1'b0, -1, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    exp_q = '{10, 20};
    send_row();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus8.out_valid !== 1'b0 || bus0.out_valid !== 1'b0 || bus8.num_out !== 16'd0 ||
        bus8.den_out !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset: out_valid=%b/%b num=%0d den=%0d, want 0 0 0 0",
               bus8.out_valid, bus0.out_valid, bus8.num_out, bus8.den_out);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_release: in_ready=%b out_valid=%b, want 1 0", bus8.in_ready, bus8.out_valid);
    end
    exp_q = '{7};
    send_row();
    check_emit("after_reset", 1'b0, -1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_guard();
    test_truncation();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
